// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline types: data width, bubble encoding and the
// {pc, instr} record buffered by the fetch stage.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] BUBBLE_INSTR = 32'h0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between the fetch unit
// (master) and the instruction memory (slave).
interface fetch_unit_if;
    import riscv_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous clear; DEPTH must be a power of two so
// the pointers wrap for free.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_clear,
    input  logic [WIDTH-1:0]       i_data,
    output logic                   o_empty,
    output logic                   o_full,
    output logic [WIDTH-1:0]       o_head,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [AW:0]      r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_head    = r_mem[r_rd];
    assign o_count   = r_cnt;
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
        end
    end

    // Storage needs no reset: occupancy alone decides what is readable.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, issues credit-limited in-order fetches and buffers
// returned instructions for IF/ID, honouring stall and redirect.
module fetch_unit import riscv_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall_if,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    fetch_unit_if.master    imem,
    output logic [XLEN-1:0] instr_if,
    output logic [XLEN-1:0] pc_if,
    output logic [XLEN-1:0] pc_plus4_if
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = $bits(fetch_entry_t);

    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_credits;
    logic [CW-1:0]   r_drop_cnt;

    logic            w_pop, w_req_valid, w_issue, w_rsp, w_dropping, w_push;
    logic [CW-1:0]   w_redir_drop;
    logic [XLEN-1:0] w_pcq_head;
    logic            w_pcq_empty, w_pcq_full;
    logic [CW-1:0]   w_pcq_count;
    logic [EW-1:0]   w_fifo_head_raw;
    fetch_entry_t    w_fifo_head;
    fetch_entry_t    w_fifo_in;
    logic            w_fifo_empty, w_fifo_full;
    logic [CW-1:0]   w_fifo_count;
    logic            w_unused;

    assign w_pop       = !stall_if && !w_fifo_empty && !redirect_valid;
    // A same-cycle pop frees a credit, which keeps k=1 streaming at full rate.
    assign w_req_valid = !reset && !redirect_valid &&
                         ((r_credits < CW'(DEPTH)) || w_pop);
    assign w_issue     = w_req_valid && imem.imem_req_ready;
    assign w_rsp       = imem.imem_rsp_valid;
    assign w_dropping  = w_rsp && (r_drop_cnt != '0);
    assign w_push      = w_rsp && (r_drop_cnt == '0) && !redirect_valid;

    // Everything still outstanding after this cycle's response becomes stale.
    assign w_redir_drop = r_credits - w_fifo_count - CW'(w_rsp);

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = r_fetch_pc;

    assign w_fifo_in.pc    = w_pcq_head;
    assign w_fifo_in.instr = imem.imem_rsp_data;
    assign w_fifo_head     = fetch_entry_t'(w_fifo_head_raw);
    assign w_unused        = &{1'b0, w_pcq_empty, w_pcq_full, w_pcq_count, w_fifo_full};

    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_pc_queue (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_issue),
        .i_pop   (w_rsp),
        .i_clear (1'b0),
        .i_data  (r_fetch_pc),
        .o_empty (w_pcq_empty),
        .o_full  (w_pcq_full),
        .o_head  (w_pcq_head),
        .o_count (w_pcq_count)
    );

    sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_instr_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (redirect_valid),
        .i_data  (w_fifo_in),
        .o_empty (w_fifo_empty),
        .o_full  (w_fifo_full),
        .o_head  (w_fifo_head_raw),
        .o_count (w_fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_credits  <= '0;
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
            r_drop_cnt <= w_redir_drop;
            r_credits  <= w_redir_drop;
        end else begin
            if (w_issue)    r_fetch_pc <= r_fetch_pc + 32'd4;
            if (w_dropping) r_drop_cnt <= r_drop_cnt - 1'b1;
            r_credits <= r_credits + CW'(w_issue) - CW'(w_pop) - CW'(w_dropping);
        end
    end

    always_comb begin
        instr_if    = BUBBLE_INSTR;
        pc_if       = '0;
        pc_plus4_if = '0;
        if (!w_fifo_empty) begin
            instr_if    = w_fifo_head.instr;
            pc_if       = w_fifo_head.pc;
            pc_plus4_if = w_fifo_head.pc + 32'd4;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomised check of fetch_unit against a latency-programmable
// instruction memory whose data word is the bitwise inverse of its address.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] RPC   = 32'h100;
    localparam int          DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_if = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instr_if, pc_if, pc_plus4_if;

    fetch_unit_if imem();

    fetch_unit #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_if       (stall_if),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem           (imem),
        .instr_if       (instr_if),
        .pc_if          (pc_if),
        .pc_plus4_if    (pc_plus4_if)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [31:0] addr; int due; } req_t;
    req_t q[$];
    int   cyc = 0;
    int   lat = 1;
    bit   rand_lat = 1'b0;
    int   last_due = 0;

    // Memory: responds in order, one per cycle, at the earliest 'lat' cycles after acceptance.
    initial begin
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (q.size() > 0 && q[0].due <= cyc) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = ~q[0].addr;
                void'(q.pop_front());
            end else begin
                imem.imem_rsp_valid = 1'b0;
            end
            @(negedge clk);
            if (reset) begin
                q.delete();
                last_due = 0;
            end else if (imem.imem_req_valid && imem.imem_req_ready) begin
                req_t r;
                int   d;
                d = cyc + (rand_lat ? $urandom_range(1, 4) : lat);
                if (d <= last_due) d = last_due + 1;
                last_due = d;
                r.addr = imem.imem_req_addr;
                r.due  = d;
                q.push_back(r);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] oexp(input bit v, input logic [31:0] pc);
        return v ? {~pc, pc, pc + 32'd4} : 96'h0;
    endfunction

    function automatic logic [95:0] oact();
        return {instr_if, pc_if, pc_plus4_if};
    endfunction

    function automatic logic [95:0] ract();
        return {63'h0, imem.imem_req_valid, imem.imem_req_addr};
    endfunction

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset(input int n);
        step();
        reset = 1'b1; stall_if = 1'b0; redirect_valid = 1'b0;
        imem.imem_req_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            @(negedge clk);
            chk("rst_req_valid", {95'h0, imem.imem_req_valid}, 96'h0);
            if (i > 0) begin
                chk("rst_req_addr", {64'h0, imem.imem_req_addr}, {64'h0, RPC});
                chk("rst_out", oact(), 96'h0);
            end
        end
    endtask

    typedef struct {
        bit          ready;
        bit          stall;
        bit          ev;
        logic [31:0] ea;
        bit          ov;
        logic [31:0] opc;
    } vec_t;

    function automatic vec_t mk(bit r, bit s, bit ev, logic [31:0] ea, bit ov, logic [31:0] opc);
        vec_t v;
        v.ready = r; v.stall = s; v.ev = ev; v.ea = ea; v.ov = ov; v.opc = opc;
        return v;
    endfunction

    vec_t vt[19];

    initial begin
        int          k;
        bit          seen;
        logic [31:0] exp_pc;
        int          pops;

        // reset, backpressure and stall with k=1 after release
        vt[0]  = mk(1, 0, 1, 32'h100, 0, 32'h0);
        vt[1]  = mk(1, 0, 1, 32'h104, 0, 32'h0);
        vt[2]  = mk(0, 0, 1, 32'h108, 1, 32'h100);
        vt[3]  = mk(0, 0, 1, 32'h108, 1, 32'h104);
        vt[4]  = mk(0, 0, 1, 32'h108, 0, 32'h0);
        vt[5]  = mk(1, 0, 1, 32'h108, 0, 32'h0);
        vt[6]  = mk(1, 0, 1, 32'h10C, 0, 32'h0);
        vt[7]  = mk(1, 0, 1, 32'h110, 1, 32'h108);
        vt[8]  = mk(1, 0, 1, 32'h114, 1, 32'h10C);
        vt[9]  = mk(1, 1, 1, 32'h118, 1, 32'h110);
        vt[10] = mk(1, 1, 1, 32'h11C, 1, 32'h110);
        vt[11] = mk(1, 1, 0, 32'h120, 1, 32'h110);
        vt[12] = mk(1, 1, 0, 32'h120, 1, 32'h110);
        vt[13] = mk(1, 1, 0, 32'h120, 1, 32'h110);
        vt[14] = mk(1, 0, 1, 32'h120, 1, 32'h110);
        vt[15] = mk(1, 0, 1, 32'h124, 1, 32'h114);
        vt[16] = mk(1, 0, 1, 32'h128, 1, 32'h118);
        vt[17] = mk(1, 0, 1, 32'h12C, 1, 32'h11C);
        vt[18] = mk(1, 0, 1, 32'h130, 1, 32'h120);

        imem.imem_req_ready = 1'b1;
        lat = 1;
        do_reset(3);
        for (int i = 0; i < 19; i++) begin
            step();
            reset = 1'b0;
            imem.imem_req_ready = vt[i].ready;
            stall_if = vt[i].stall;
            @(negedge clk);
            chk($sformatf("vec%0d_req", i), ract(), {63'h0, vt[i].ev, vt[i].ea});
            chk($sformatf("vec%0d_out", i), oact(), oexp(vt[i].ov, vt[i].opc));
        end

        // redirect with three requests in flight, k=3
        lat = 3;
        do_reset(2);
        for (int i = 0; i < 3; i++) begin
            step(); reset = 1'b0;
            @(negedge clk);
            chk($sformatf("rd_issue%0d", i), ract(), {63'h0, 1'b1, RPC + 32'(4 * i)});
        end
        step(); redirect_valid = 1'b1; redirect_pc = 32'h2000;
        @(negedge clk);
        chk("rd_cycle_valid", {95'h0, imem.imem_req_valid}, 96'h0);
        step(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("rd_t1_req", ract(), {63'h0, 1'b1, 32'h2000});
        chk("rd_t1_out", oact(), 96'h0);
        for (int i = 0; i < 3; i++) begin
            step(); @(negedge clk);
            chk($sformatf("rd_drop_out%0d", i), oact(), 96'h0);
        end
        step(); @(negedge clk);
        chk("rd_first_out", oact(), oexp(1, 32'h2000));

        // redirect coinciding with stall and an arriving response
        step(); stall_if = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3001;
        @(negedge clk);
        chk("rs_hold_out", oact(), oexp(1, 32'h2004));
        chk("rs_rsp_present", {95'h0, imem.imem_rsp_valid}, 96'h1);
        step(); stall_if = 1'b0; redirect_valid = 1'b0;
        @(negedge clk);
        chk("rs_t1_req", ract(), {63'h0, 1'b1, 32'h3000});
        chk("rs_t1_out", oact(), 96'h0);
        k = 0; seen = 1'b0;
        while (!seen && k < 12) begin
            step(); @(negedge clk); k++;
            if (instr_if != 32'h0) seen = 1'b1;
        end
        chk("rs_first_out", oact(), oexp(1, 32'h3000));
        chk("rs_first_delay", 96'(k), 96'd4);

        // PC wrap and alignment of the redirect target
        lat = 1;
        do_reset(2);
        step(); reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        chk("wr_cycle_valid", {95'h0, imem.imem_req_valid}, 96'h0);
        step(); redirect_valid = 1'b0;
        @(negedge clk);
        chk("wr_req0", ract(), {63'h0, 1'b1, 32'hFFFF_FFFC});
        step(); @(negedge clk);
        chk("wr_req1", ract(), {63'h0, 1'b1, 32'h0});
        chk("wr_out_bubble", oact(), 96'h0);
        step(); @(negedge clk);
        chk("wr_out0", oact(), {32'h3, 32'hFFFF_FFFC, 32'h0});
        step(); @(negedge clk);
        chk("wr_out1", oact(), {32'hFFFF_FFFF, 32'h0, 32'h4});

        // random latency, ready, stall and redirect against a PC reference
        rand_lat = 1'b1;
        do_reset(2);
        exp_pc = RPC;
        pops = 0;
        for (int i = 0; i < 1500; i++) begin
            step();
            reset = 1'b0;
            imem.imem_req_ready = ($urandom_range(0, 4) != 0);
            stall_if       = ($urandom_range(0, 9) < 3);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc    = $urandom;
            @(negedge clk);
            chk("rnd_inflight", {95'h0, (q.size() <= DEPTH)}, 96'h1);
            if (instr_if != 32'h0) begin
                chk("rnd_out", oact(), oexp(1, exp_pc));
                if (!stall_if && !redirect_valid) begin
                    exp_pc = exp_pc + 32'd4;
                    pops++;
                end
            end
            if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
        end
        chk("rnd_progress", {95'h0, (pops >= 200)}, 96'h1);
        redirect_valid = 1'b0;
        stall_if = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
